load_store_unit: RTL and testbench

//   Sits between the CPU execute stage and the word-wide, combinational-read data memory; drives the memory's address/write_en/write_data and consumes read_data.

---
 rtl/lsu_pkg.sv | 19 +
 rtl/byte_lane_unit.sv | 41 ++++
 rtl/load_store_unit.sv | 148 ++++++++++++++
 tb/tb_load_store_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    RMW_RD,
    RMW_WR,
    RESP
  } lsu_state_e;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  // Byte lane within the addressed word.
  function automatic logic [1:0] lane_sel(input logic [31:0] addr);
    return 2'(addr & ~ALIGN_MASK);
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational byte-lane helpers: merge a byte into a word, extract a
// zero-extended byte, and rotate a word right by whole bytes.
module byte_lane_unit (
  input  logic [31:0] word_in,
  input  logic [1:0]  lane,
  input  logic [7:0]  byte_in,
  output logic [31:0] merged,
  output logic [31:0] extracted,
  output logic [31:0] rotated
);

  // Lane-indexed merge, extract and rotate.
  always_comb begin
    merged    = word_in;
    extracted = '0;
    rotated   = word_in;
    case (lane)
      2'd0: begin
        merged[7:0]    = byte_in;
        extracted[7:0] = word_in[7:0];
        rotated        = word_in;
      end
      2'd1: begin
        merged[15:8]   = byte_in;
        extracted[7:0] = word_in[15:8];
        rotated        = {word_in[7:0], word_in[31:8]};
      end
      2'd2: begin
        merged[23:16]  = byte_in;
        extracted[7:0] = word_in[23:16];
        rotated        = {word_in[15:0], word_in[31:16]};
      end
      default: begin
        merged[31:24]  = byte_in;
        extracted[7:0] = word_in[31:24];
        rotated        = {word_in[23:0], word_in[31:24]};
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-wide memory with
// combinational read. Byte stores use read-modify-write.
// Optional macro ALIGN_FAULT_EN: misaligned word accesses fault instead of
// using rotated loads / unrotated stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        mem_reset_n,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic        cpu_write,
  input  logic        cpu_byte,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_done,
  output logic        cpu_fault,
  output logic [31:0] cpu_rdata,
  output logic [31:0] mem_address,
  output logic        mem_write_en,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        byte_q, byte_d;
  logic        fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] word_q, word_d;

  logic        range_err;
  logic        align_err;
  logic [31:0] lane_word;
  logic [31:0] merged, extracted, rotated;

  assign range_err = cpu_addr > 32'(MEM_BYTES - 4);
`ifdef ALIGN_FAULT_EN
  assign align_err = !cpu_byte && (lane_sel(cpu_addr) != 2'd0);
`else
  assign align_err = 1'b0;
`endif

  // Merge operates on the latched word; load shaping on live read data.
  assign lane_word = (state_q == RMW_WR) ? word_q : mem_read_data;

  byte_lane_unit u_lane (
    .word_in   (lane_word),
    .lane      (lane_sel(addr_q)),
    .byte_in   (wdata_q[7:0]),
    .merged    (merged),
    .extracted (extracted),
    .rotated   (rotated)
  );

  // State register and captured request fields.
  always_ff @(posedge clk or negedge mem_reset_n) begin
    if (!mem_reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      byte_q  <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      byte_q  <= byte_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      word_q  <= word_d;
    end
  end

  // Next-state sequencing, request capture and load-result update.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    byte_d  = byte_q;
    fault_d = fault_q;
    rdata_d = rdata_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (cpu_valid) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          write_d = cpu_write;
          byte_d  = cpu_byte;
          fault_d = range_err || align_err;
          if (range_err || align_err)  state_d = RESP;
          else if (cpu_write && cpu_byte) state_d = RMW_RD;
          else                         state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!write_q) rdata_d = byte_q ? extracted : rotated;
        state_d = RESP;
      end
      RMW_RD: begin
        word_d  = mem_read_data;
        state_d = RMW_WR;
      end
      RMW_WR:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory port and response outputs decoded from the current state.
  always_comb begin
    mem_address    = '0;
    mem_write_en   = 1'b0;
    mem_write_data = '0;
    case (state_q)
      ACCESS: begin
        mem_address = addr_q & ALIGN_MASK;
        if (write_q) begin
          mem_write_en   = 1'b1;
          mem_write_data = wdata_q;
        end
      end
      RMW_RD: mem_address = addr_q & ALIGN_MASK;
      RMW_WR: begin
        mem_address    = addr_q & ALIGN_MASK;
        mem_write_en   = 1'b1;
        mem_write_data = merged;
      end
      default: ;
    endcase
  end

  assign cpu_ready = (state_q == IDLE);
  assign cpu_done  = (state_q == RESP);
  assign cpu_fault = (state_q == RESP) && fault_q;
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, reset-abort
// sequence, then randomized requests against a behavioural model.
module tb_load_store_unit;

  localparam int unsigned MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        mem_reset_n = 1'b0;
  logic        cpu_valid = 1'b0;
  logic        cpu_ready;
  logic        cpu_write = 1'b0;
  logic        cpu_byte = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_done;
  logic        cpu_fault;
  logic [31:0] cpu_rdata;
  logic [31:0] mem_address;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  int          wr_count = 0;

  int vectors = 0;
  int miscompares = 0;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk            (clk),
    .mem_reset_n    (mem_reset_n),
    .cpu_valid      (cpu_valid),
    .cpu_ready      (cpu_ready),
    .cpu_write      (cpu_write),
    .cpu_byte       (cpu_byte),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_done       (cpu_done),
    .cpu_fault      (cpu_fault),
    .cpu_rdata      (cpu_rdata),
    .mem_address    (mem_address),
    .mem_write_en   (mem_write_en),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  // Word-wide memory with combinational read.
  assign mem_read_data = mem[mem_address[9:2]];
  always @(posedge clk) begin
    if (mem_write_en) begin
      mem[mem_address[9:2]] <= mem_write_data;
      wr_count = wr_count + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d,
                        output logic f, output logic [31:0] r, output int lat,
                        output int wr, output logic rdy);
    int start;
    @(negedge clk);
    cpu_valid = 1'b1; cpu_write = w; cpu_byte = b; cpu_addr = a; cpu_wdata = d;
    start = wr_count;
    @(posedge clk);
    #1 cpu_valid = 1'b0;
    lat = 0; f = 1'b0; r = '0; rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (cpu_done) begin
        f = cpu_fault; r = cpu_rdata; rdy = cpu_ready;
        break;
      end
    end
    @(posedge clk);
    #1 wr = wr_count - start;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(cpu_ready), 32'd1);
    check({tag, "_done"},  32'(cpu_done),  32'd0);
    check({tag, "_fault"}, 32'(cpu_fault), 32'd0);
    check({tag, "_rdata"}, cpu_rdata, 32'd0);
    check({tag, "_maddr"}, mem_address, 32'd0);
    check({tag, "_mwe"},   32'(mem_write_en), 32'd0);
    check({tag, "_mwd"},   mem_write_data, 32'd0);
  endtask

  typedef struct {
    logic        w;
    logic        b;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_fault;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_wr;
  } vec_t;

  vec_t vt [10];

  initial begin
    logic        f, rdy;
    logic [31:0] r;
    int          lat, wr;
    logic        ref_fault;
    logic [31:0] ref_rdata;
    int          ref_lat, ref_wr, diffs;
`ifdef ALIGN_FAULT_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h08] = 32'hAABB_CCDD;
    mem[8'hFF] = 32'hCAFE_F00D;

    #3 check_reset_outputs("reset");
    @(negedge clk); mem_reset_n = 1'b1;

    vt[0] = '{1'b1, 1'b0, 32'h010, 32'h0000_0014, 1'b0, 32'h0, 2, 1};
    vt[1] = '{1'b0, 1'b0, 32'h010, 32'h0,          1'b0, 32'h0000_0014, 2, 0};
    vt[2] = '{1'b1, 1'b1, 32'h022, 32'hFFFF_FF11, 1'b0, 32'h0000_0014, 3, 1};
    vt[3] = '{1'b0, 1'b0, 32'h020, 32'h0,          1'b0, 32'hAA11_CCDD, 2, 0};
    vt[4] = '{1'b1, 1'b0, 32'h020, 32'hAABB_CCDD, 1'b0, 32'hAA11_CCDD, 2, 1};
    vt[5] = '{1'b0, 1'b1, 32'h023, 32'h0,          1'b0, 32'h0000_00AA, 2, 0};
    vt[6] = '{1'b0, 1'b1, 32'h020, 32'h0,          1'b0, 32'h0000_00DD, 2, 0};
    if (ALIGN) vt[7] = '{1'b0, 1'b0, 32'h021, 32'h0, 1'b1, 32'h0000_00DD, 1, 0};
    else       vt[7] = '{1'b0, 1'b0, 32'h021, 32'h0, 1'b0, 32'hDDAA_BBCC, 2, 0};
    vt[8] = '{1'b1, 1'b0, 32'h3FD, 32'h1234_5678, 1'b1, vt[7].exp_rdata, 1, 0};
    vt[9] = '{1'b0, 1'b0, 32'h3FC, 32'h0,          1'b0, 32'hCAFE_F00D, 2, 0};

    for (int i = 0; i < 10; i++) begin
      do_req(vt[i].w, vt[i].b, vt[i].addr, vt[i].wdata, f, r, lat, wr, rdy);
      check($sformatf("v%0d_fault", i), 32'(f), 32'(vt[i].exp_fault));
      check($sformatf("v%0d_rdata", i), r, vt[i].exp_rdata);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].exp_lat));
      check($sformatf("v%0d_writes", i), 32'(wr), 32'(vt[i].exp_wr));
      check($sformatf("v%0d_ready_in_resp", i), 32'(rdy), 32'd0);
    end
    check("mem_0x10", mem[8'h04], 32'h0000_0014);
    check("mem_0x20", mem[8'h08], 32'hAABB_CCDD);

    // Reset asserted while the byte store is in its write cycle.
    mem[8'h10] = 32'h0102_0304;
    @(negedge clk);
    cpu_valid = 1'b1; cpu_write = 1'b1; cpu_byte = 1'b1; cpu_addr = 32'h41; cpu_wdata = 32'h55;
    @(posedge clk);
    #1 cpu_valid = 1'b0;
    @(posedge clk);
    #1 check("rmw_wr_we", 32'(mem_write_en), 32'd1);
    wr = wr_count;
    mem_reset_n = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    mem_reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("abort_writes", 32'(wr_count - wr), 32'd0);
    check("abort_mem", mem[8'h10], 32'h0102_0304);
    do_req(1'b0, 1'b0, 32'h40, 32'h0, f, r, lat, wr, rdy);
    check("post_abort_ld", r, 32'h0102_0304);
    check("post_abort_lat", 32'(lat), 32'd2);
    do_req(1'b1, 1'b1, 32'h41, 32'h55, f, r, lat, wr, rdy);
    check("post_abort_strb_writes", 32'(wr), 32'd1);
    do_req(1'b0, 1'b0, 32'h40, 32'h0, f, r, lat, wr, rdy);
    check("post_abort_strb_val", r, 32'h0102_5504);

    // Randomized traffic against a byte-level behavioural model.
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    ref_rdata = 32'h0102_5504;
    for (int n = 0; n < 300; n++) begin
      logic        w, b;
      logic [31:0] a, d, word;
      int          sh;
      w = 1'($urandom); b = 1'($urandom); d = $urandom;
      a = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(1024, 70000)) : 32'($urandom_range(0, 1020));
      sh = 8 * int'(a % 4);
      ref_fault = (a > MEM_BYTES - 4) || (ALIGN && !b && (a % 4 != 0));
      ref_lat = 2; ref_wr = 0;
      if (ref_fault) begin
        ref_lat = 1;
      end else begin
        word = ref_mem[a / 4];
        if (w && b) begin
          ref_mem[a / 4] = (word & ~(32'hFF << sh)) | ({24'h0, d[7:0]} << sh);
          ref_lat = 3; ref_wr = 1;
        end else if (w) begin
          ref_mem[a / 4] = d; ref_wr = 1;
        end else if (b) begin
          ref_rdata = (word >> sh) & 32'hFF;
        end else begin
          ref_rdata = 32'({word, word} >> sh);
        end
      end
      do_req(w, b, a, d, f, r, lat, wr, rdy);
      check($sformatf("r%0d_fault", n), 32'(f), 32'(ref_fault));
      check($sformatf("r%0d_rdata", n), r, ref_rdata);
      check($sformatf("r%0d_lat", n), 32'(lat), 32'(ref_lat));
      check($sformatf("r%0d_writes", n), 32'(wr), 32'(ref_wr));
    end
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("final_mem_diff_words", 32'(diffs), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

endmodule
